// File: rtl/button_conditioner.sv
// Synchronises and debounces active-low push-buttons into clean level/press/release signals.
// Optional auto-repeat of press events is enabled with `define BUTTON_CONDITIONER_AUTOREPEAT_EN.
module button_conditioner #(
    parameter int N_BUTTONS       = 2,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 13500000,
    parameter int REPEAT_PERIOD   = 2700000,
    parameter int RPT_W           = 24
) (
    input  logic                 crystalCLK,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] btn_raw_n,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] btn_press,
    output logic [N_BUTTONS-1:0] btn_release
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BUTTONS-1:0] sync1_r;
    logic [N_BUTTONS-1:0] sync2_r;
    logic [N_BUTTONS-1:0] stable_r;
    logic [N_BUTTONS-1:0] stable_s;
    logic [N_BUTTONS-1:0] accept_s;
    logic [N_BUTTONS-1:0] press_r;
    logic [N_BUTTONS-1:0] press_s;
    logic [N_BUTTONS-1:0] release_r;
    logic [N_BUTTONS-1:0] release_s;
    logic [CNT_W-1:0]     cnt_r [N_BUTTONS];
    logic [CNT_W-1:0]     cnt_s [N_BUTTONS];
    logic [N_BUTTONS-1:0] repeat_s;

    // Two-flop synchroniser, inverting so that 1 means pressed.
    always_ff @(posedge crystalCLK) begin
        if (rst) begin
            sync1_r <= {N_BUTTONS{1'b0}};
            sync2_r <= {N_BUTTONS{1'b0}};
        end else begin
            sync1_r <= ~btn_raw_n;
            sync2_r <= sync1_r;
        end
    end

    // Debounce decision: any sample matching the stable level restarts the count.
    always_comb begin
        stable_s = stable_r;
        accept_s = {N_BUTTONS{1'b0}};
        for (int i = 0; i < N_BUTTONS; i++) begin
            cnt_s[i] = cnt_r[i];
            if (sync2_r[i] == stable_r[i]) begin
                cnt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_LAST) begin
                stable_s[i] = sync2_r[i];
                cnt_s[i]    = CNT_ZERO;
                accept_s[i] = 1'b1;
            end else begin
                cnt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam logic [RPT_W-1:0] RPT_ZERO        = {RPT_W{1'b0}};
    localparam logic [RPT_W-1:0] RPT_ONE         = {{(RPT_W-1){1'b0}}, 1'b1};
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0]     rpt_r [N_BUTTONS];
    logic [RPT_W-1:0]     rpt_s [N_BUTTONS];
    logic [N_BUTTONS-1:0] rpt_phase_r;
    logic [N_BUTTONS-1:0] rpt_phase_s;

    // Hold timer: first wait is REPEAT_DELAY, then every REPEAT_PERIOD; a release edge suppresses firing.
    always_comb begin
        repeat_s    = {N_BUTTONS{1'b0}};
        rpt_phase_s = rpt_phase_r;
        for (int i = 0; i < N_BUTTONS; i++) begin
            rpt_s[i] = rpt_r[i];
            if (!stable_r[i] || accept_s[i]) begin
                rpt_s[i]       = RPT_ZERO;
                rpt_phase_s[i] = 1'b0;
            end else if (rpt_r[i] == (rpt_phase_r[i] ? RPT_PERIOD_LAST : RPT_DELAY_LAST)) begin
                rpt_s[i]       = RPT_ZERO;
                rpt_phase_s[i] = 1'b1;
                repeat_s[i]    = 1'b1;
            end else begin
                rpt_s[i] = rpt_r[i] + RPT_ONE;
            end
        end
    end

    // Repeat timer state.
    always_ff @(posedge crystalCLK) begin
        if (rst) begin
            rpt_phase_r <= {N_BUTTONS{1'b0}};
            for (int i = 0; i < N_BUTTONS; i++) begin
                rpt_r[i] <= RPT_ZERO;
            end
        end else begin
            rpt_phase_r <= rpt_phase_s;
            for (int i = 0; i < N_BUTTONS; i++) begin
                rpt_r[i] <= rpt_s[i];
            end
        end
    end
`else
    // Without auto-repeat only the accepted press produces a press event.
    always_comb begin
        repeat_s = {N_BUTTONS{1'b0}};
    end
`endif

    // Event pulses; press and release are mutually exclusive per channel.
    always_comb begin
        press_s   = (accept_s & sync2_r) | repeat_s;
        release_s = accept_s & ~sync2_r;
    end

    // Debounce state and registered outputs.
    always_ff @(posedge crystalCLK) begin
        if (rst) begin
            stable_r  <= {N_BUTTONS{1'b0}};
            press_r   <= {N_BUTTONS{1'b0}};
            release_r <= {N_BUTTONS{1'b0}};
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            stable_r  <= stable_s;
            press_r   <= press_s;
            release_r <= release_s;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt_r[i] <= cnt_s[i];
            end
        end
    end

    assign btn_level   = stable_r;
    assign btn_press   = press_r;
    assign btn_release = release_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random stimulus against a
// window-based reference model (a level is accepted after D consecutive opposite samples).
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int MAXE = 4096;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic       crystalCLK;
    logic       rst;
    logic [1:0] btn_raw_n;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;

    button_conditioner #(
        .N_BUTTONS(2), .DEBOUNCE_CYCLES(D), .CNT_W(20),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .RPT_W(8)
    ) dut (
        .crystalCLK (crystalCLK),
        .rst        (rst),
        .btn_raw_n  (btn_raw_n),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    initial crystalCLK = 1'b0;
    always #5 crystalCLK = ~crystalCLK;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // reference model state
    int         edge_n = 0;
    bit         s2b [2][MAXE];
    logic [1:0] m_s1 = 2'b00;
    logic [1:0] m_s2 = 2'b00;
    logic [1:0] m_stable = 2'b00;
    int         last_accept [2] = '{0, 0};
    int         press_edge  [2] = '{0, 0};
    logic [1:0] exp_press;
    logic [1:0] exp_release;

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic step(input logic [1:0] raw, input logic r);
        bit ok;
        int d;
        btn_raw_n = raw;
        rst       = r;
        @(posedge crystalCLK);
        edge_n++;
        exp_press   = 2'b00;
        exp_release = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            s2b[ch][edge_n] = m_s2[ch];
            if (r) begin
                m_stable[ch]    = 1'b0;
                last_accept[ch] = edge_n;
            end else begin
                ok = (edge_n - last_accept[ch] >= D);
                if (ok) begin
                    for (int j = 0; j < D; j++) begin
                        if (s2b[ch][edge_n - j] == m_stable[ch]) ok = 1'b0;
                    end
                end
                if (ok) begin
                    m_stable[ch]    = ~m_stable[ch];
                    last_accept[ch] = edge_n;
                    if (m_stable[ch]) begin
                        exp_press[ch]  = 1'b1;
                        press_edge[ch] = edge_n;
                    end else begin
                        exp_release[ch] = 1'b1;
                    end
                end else if (RPT_EN && m_stable[ch]) begin
                    d = edge_n - press_edge[ch];
                    if (d == RD || (d > RD && ((d - RD) % RP) == 0)) exp_press[ch] = 1'b1;
                end
            end
        end
        m_s2 = r ? 2'b00 : m_s1;
        m_s1 = r ? 2'b00 : ~raw;
        #1;
        check("level", btn_level, m_stable);
        check("press", btn_press, exp_press);
        check("release", btn_release, exp_release);
    endtask

    initial begin
        logic [1:0] cur;
        int         npress;
        int         npulse;
        logic       r;
        btn_raw_n = 2'b11;
        rst       = 1'b1;

        // reset held 3 cycles with both buttons pressed
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 1'b1);
            check("rst_out", btn_level | btn_press | btn_release, 2'b00);
        end
        for (int i = 1; i <= 8; i++) begin
            step(2'b00, 1'b0);
            if (i == 5) check("rst_level_before", btn_level, 2'b00);
            if (i == 6) begin
                check("rst_press6", btn_press, 2'b11);
                check("rst_level6", btn_level, 2'b11);
            end
        end

        // release both
        for (int i = 1; i <= 8; i++) begin
            step(2'b11, 1'b0);
            if (i == 6) check("rel_both", btn_release, 2'b11);
        end

        // clean press of X held long enough for auto-repeat
        npress = 0;
        for (int i = 1; i <= 40; i++) begin
            step(2'b10, 1'b0);
            if (i == 5) check("x_press_early", btn_press, 2'b00);
            if (i == 6) check("x_press6", btn_press, 2'b01);
            if (btn_press[0]) npress++;
            if (btn_release != 2'b00) npress += 100;
        end
        check("x_level", btn_level, 2'b01);
        check("x_npress", 2'(npress), RPT_EN ? 2'(10) : 2'(1));
        checks++;
        assert (npress == (RPT_EN ? 10 : 1)) passes++;
        else begin
            fails++;
            $error("FAIL x_press_count observed=%0d expected=%0d", npress, RPT_EN ? 10 : 1);
        end

        // release X
        for (int i = 1; i <= 8; i++) begin
            step(2'b11, 1'b0);
            if (i == 6) check("x_release6", btn_release, 2'b01);
        end

        // bounce shorter than the debounce window
        npulse = 0;
        for (int i = 0; i < 3; i++) begin step(2'b10, 1'b0); npulse += int'(btn_press[0]); end
        step(2'b11, 1'b0); npulse += int'(btn_press[0]);
        for (int i = 0; i < 3; i++) begin step(2'b10, 1'b0); npulse += int'(btn_press[0]); end
        for (int i = 0; i < 8; i++) begin step(2'b11, 1'b0); npulse += int'(btn_press[0]); end
        check("bounce_level", btn_level, 2'b00);
        checks++;
        assert (npulse == 0) passes++;
        else begin
            fails++;
            $error("FAIL bounce_pulses observed=%0d expected=0", npulse);
        end

        // Y pressed, then X press and Y release on the same edge
        for (int i = 0; i < 8; i++) step(2'b01, 1'b0);
        check("y_level", btn_level, 2'b10);
        for (int i = 1; i <= 8; i++) begin
            step(2'b10, 1'b0);
            if (i == 6) begin
                check("simul_press", btn_press, 2'b01);
                check("simul_release", btn_release, 2'b10);
            end
        end

        // reset mid-debounce, button held through it
        for (int i = 0; i < 8; i++) step(2'b11, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b10, 1'b0);
        step(2'b10, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            step(2'b10, 1'b0);
            if (i == 5) check("midrst_early", btn_press, 2'b00);
            if (i == 6) check("midrst_press6", btn_press, 2'b01);
        end

        // random stimulus against the model
        cur = 2'b11;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) cur = cur ^ 2'($urandom_range(1, 3));
            r = ($urandom_range(0, 149) == 0);
            step(cur, r);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Per-button input conditioner between the Nano4K's raw active-low push-buttons (X, Y) and the sprite animation logic. It synchronises each raw pin into the `crystalCLK` domain and debounces it with a per-button stability counter. For each button it produces a clean pressed level plus single-cycle press and release events. Sprite and animation controllers consume only these outputs and never see raw pins.

## Interface
- `N_BUTTONS`, 2: number of independent button channels (bit 0 = X, bit 1 = Y).
- `DEBOUNCE_CYCLES`, 270000: consecutive stable samples required to accept a new level (10 ms at 27 MHz); legal range 2..2^CNT_W−1.
- `CNT_W`, 20: width of each debounce counter.
- `REPEAT_DELAY`, 13500000: cycles of hold before the first auto-repeat event (used only with `AUTOREPEAT_EN`).
- `REPEAT_PERIOD`, 2700000: cycles between subsequent auto-repeat events (used only with `AUTOREPEAT_EN`).
- `RPT_W`, 24: width of the repeat counter.
- `crystalCLK`  input  1  sole clock, 27 MHz crystal.
- `rst`  input  1  synchronous, active-high reset.
- `btn_raw_n`  input  N_BUTTONS  raw pins, low = pressed, asynchronous to clock.
- `btn_level`  output  N_BUTTONS  debounced state, 1 = pressed.
- `btn_press`  output  N_BUTTONS  one-cycle pulse on accepted press (and on repeats when enabled).
- `btn_release`  output  N_BUTTONS  one-cycle pulse on accepted release.

## Operation
- Channels are fully independent; all statements below apply per bit.
- Two-flop synchroniser: `sync1 <= ~btn_raw_n`, `sync2 <= sync1` (pressed = 1).
- State per channel: `stable` (drives `btn_level`) and `cnt[CNT_W-1:0]`.
- If `sync2 == stable`, then `cnt <= 0`. Any matching sample restarts the count, so a glitch shorter than DEBOUNCE_CYCLES is discarded.
- If `sync2 != stable` and `cnt == DEBOUNCE_CYCLES-1`, then `stable <= sync2` and `cnt <= 0`. In the same edge, `btn_press <= sync2` and `btn_release <= ~sync2`.
- If `sync2 != stable` and `cnt != DEBOUNCE_CYCLES-1`, then `cnt <= cnt+1`.
- Pulses are registered. Each pulse is high for exactly one cycle; otherwise it is 0 every cycle.
- `btn_press` and `btn_release` of the same channel are never high together. Events on different channels may coincide.
- The counter never wraps because it is cleared at DEBOUNCE_CYCLES−1.
- Reset values, applied at the first edge with `rst`=1:
  - `sync1`, `sync2`, `stable`, `cnt`, and all pulses are 0.
  - `btn_level`, `btn_press`, and `btn_release` are all 0.
- Reset mid-debounce discards the partial count. A button held through reset is reported as a fresh press, with full latency, after `rst` falls.

## Timing
- Let edge k be the first edge at which `sync1` captures a new raw level held steady.
- `btn_level` and the matching pulse change at edge k+DEBOUNCE_CYCLES+1 and are visible in the following cycle.
- The pulse drops at the next edge.
- Total press-to-event latency is DEBOUNCE_CYCLES+2 clock periods from the raw pin change, worst case. Release latency is identical.
- There is no input handshake; consumers sample pulses each cycle.

## Configuration
- Macro `BUTTON_CONDITIONER_AUTOREPEAT_EN`.
- When defined, each channel gets an `rpt[RPT_W-1:0]` counter, cleared on reset and whenever `btn_level`=0.
  - While the button is held, `rpt` counts. On reaching REPEAT_DELAY−1 it emits an extra one-cycle `btn_press` and reloads for period REPEAT_PERIOD−1.
  - It then repeats every REPEAT_PERIOD cycles until release.
  - On release, no repeat fires after the `btn_release` pulse.
- When undefined, there is no `rpt` logic and exactly one `btn_press` is emitted per accepted press.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset: hold `rst`=1 for 3 cycles with `btn_raw_n`=2'b00 → all outputs 0 during reset; `btn_level`[1:0]=2'b11 and one `btn_press`=2'b11 pulse exactly 6 cycles after `rst` falls.
- Clean press: `btn_raw_n[0]` 1→0 and held → `btn_press[0]` high for one cycle at edge k+5, `btn_level[0]`=1 from then; `btn_release` stays 0.
- Bounce: `btn_raw_n[0]` low 3 cycles, high 1, low 3, high → no pulse and `btn_level[0]` stays 0.
- Release: pressed button, raw goes high and is held → single `btn_release[0]` pulse 6 cycles later and `btn_level[0]`=0.
- Simultaneous: X press and Y release on the same edge → `btn_press`=2'b01 and `btn_release`=2'b10 in the same cycle.
- Auto-repeat (macro defined): hold X for 30 cycles after acceptance → extra `btn_press[0]` pulses at +10, +13, +16, … cycles after acceptance. With the macro undefined, only the first pulse appears.
